// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode 0/3 command master sending opcode + address, then reading up to MAX_RX_BYTES bytes.
module spi_cmd_master #(
  parameter int CLK_DIV      = 1,
  parameter int MAX_RX_BYTES = 4,
  parameter bit CPOL         = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  cmd,
  input  logic [23:0]                 addr,
  input  logic [1:0]                  addr_len,
  input  logic [3:0]                  rx_len,
  output logic                        busy,
  output logic                        done,
  output logic [8*MAX_RX_BYTES-1:0]   rx_data,
  output logic                        SPICLK,
  output logic                        SPIMOSI,
  input  logic                        SPIMISO,
  output logic                        chip_select
);
  localparam int RW   = 8 * MAX_RX_BYTES;
  localparam int NMAX = 8 * (4 + MAX_RX_BYTES);
  localparam int BW   = $clog2(NMAX + 1);
  localparam int EW   = BW + 1;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;
  state_t          state, state_nx;
  logic [7:0]      div_cnt;
  logic [EW-1:0]   edge_cnt;
  logic [BW-1:0]   bit_cnt, n_bits, rx_from, n_cap;
  logic [31:0]     tx_sr;
  logic [3:0]      rx_cl;
  logic            tick, toggle;
  always_comb begin
    rx_cl  = (rx_len > 4'(MAX_RX_BYTES)) ? 4'(MAX_RX_BYTES) : rx_len;
    n_cap  = BW'({4'(rx_cl) + 4'(addr_len) + 4'd1, 3'b000});
    tick   = div_cnt == 8'(CLK_DIV - 1);
    // every SPICLK half-period is one toggle; SHIFT holds 2N of them, the last one restoring CPOL
    toggle = tick && (state == CS_SETUP || (state == SHIFT && edge_cnt != {n_bits, 1'b0}));
    busy   = state == CS_SETUP || state == SHIFT || state == CS_HOLD;
    done   = state == DONE;
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? CS_SETUP : IDLE;
      CS_SETUP: state_nx = tick ? SHIFT : CS_SETUP;
      SHIFT:    state_nx = (tick && edge_cnt == {n_bits, 1'b0}) ? CS_HOLD : SHIFT;
      CS_HOLD:  state_nx = tick ? DONE : CS_HOLD;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= 8'd0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      n_bits      <= '0;
      rx_from     <= '0;
      tx_sr       <= 32'd0;
      rx_data     <= '0;
      SPICLK      <= CPOL;
      SPIMOSI     <= 1'b0;
      chip_select <= 1'b1;
    end else begin
      chip_select <= !(state_nx == CS_SETUP || state_nx == SHIFT || state_nx == CS_HOLD);
      div_cnt     <= (busy && !tick) ? div_cnt + 8'd1 : 8'd0;
      if (state == IDLE && start) begin
        n_bits   <= n_cap;
        rx_from  <= BW'({3'(addr_len) + 3'd1, 3'b000});
        tx_sr    <= {cmd, addr << {2'd3 - addr_len, 3'b000}};
        rx_data  <= '0;
        SPIMOSI  <= cmd[7];
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (toggle) begin
        SPICLK   <= !SPICLK;
        edge_cnt <= edge_cnt + EW'(1);
        if (!SPICLK) begin
          bit_cnt <= bit_cnt + BW'(1);
          tx_sr   <= {tx_sr[30:0], 1'b0};
          if (bit_cnt >= rx_from) rx_data <= {rx_data[RW-2:0], SPIMISO};
        end else begin
          SPIMOSI <= tx_sr[31];
        end
      end else if (state == DONE) begin
        SPIMOSI <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: randomized and directed checks of spi_cmd_master against an M25P16-like slave model.
module tb_spi_cmd_master;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sel = 1'b0, miso = 1'b0;
  logic [7:0] cmd = 8'd0;
  logic [23:0] addr = 24'd0;
  logic [1:0] addr_len = 2'd0;
  logic [3:0] rx_len = 4'd0;
  logic busy0, done0, sck0, mosi0, cs0, busy1, done1, sck1, mosi1, cs1, start0, start1;
  logic [31:0] rx0, rx1;
  logic busy, done, sck, mosi, cs;
  logic [31:0] rx;
  int checks = 0, fails = 0;
  int rises = 0, cs_base = 0, glitches = 0, bad_per = 0, dones = 0, cs_low = 0, per_exp = 40;
  time last_rise = 0;
  logic [127:0] mbits = '0;
  logic [7:0] mem [16];
  logic [7:0] stream [16];
  int o_rises, o_dones, o_cslow, o_glitch, o_badper;
  logic [31:0] o_rx, o_rx_late, o_ab_rx;
  logic [127:0] o_mbits;
  logic o_busy0, o_cs0, o_mosi0, o_overlap, o_ab_cs, o_ab_busy;

  always #10 clk = ~clk;
  assign start0 = start & !sel;
  assign start1 = start & sel;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign sck  = sel ? sck1  : sck0;
  assign mosi = sel ? mosi1 : mosi0;
  assign cs   = sel ? cs1   : cs0;
  assign rx   = sel ? rx1   : rx0;

  spi_cmd_master u_dut0 (.clk(clk), .reset(reset), .start(start0), .cmd(cmd), .addr(addr),
    .addr_len(addr_len), .rx_len(rx_len), .busy(busy0), .done(done0), .rx_data(rx0),
    .SPICLK(sck0), .SPIMOSI(mosi0), .SPIMISO(miso), .chip_select(cs0));
  spi_cmd_master #(.CLK_DIV(3), .MAX_RX_BYTES(4), .CPOL(1'b1)) u_dut1 (.clk(clk), .reset(reset),
    .start(start1), .cmd(cmd), .addr(addr), .addr_len(addr_len), .rx_len(rx_len), .busy(busy1),
    .done(done1), .rx_data(rx1), .SPICLK(sck1), .SPIMOSI(mosi1), .SPIMISO(miso), .chip_select(cs1));

  // slave response byte b of a transfer (byte 0 is the opcode slot)
  function automatic logic [7:0] slave_byte(input logic [7:0] op, input logic [23:0] a, input int b);
    if (b < 1) return 8'h00;
    if (op == 8'h9F) return b == 1 ? 8'h20 : b == 2 ? 8'h20 : b == 3 ? 8'h15 : 8'h00;
    if (op == 8'h03) return b >= 4 ? mem[4'(a + 24'(b - 4))] : 8'h00;
    return stream[b % 16];
  endfunction

  function automatic int n_of(input logic [1:0] al, input logic [3:0] rl);
    return 8 * (1 + int'(al) + (rl > 4'd4 ? 4 : int'(rl)));
  endfunction

  function automatic logic [127:0] exp_mosi(input logic [7:0] c, input logic [23:0] a, input logic [1:0] al, input logic [3:0] rl);
    logic [127:0] e = '0;
    for (int p = 0; p < n_of(al, rl); p++)
      if (p < 8) e[127-p] = c[7-p];
      else if (p < 8 + 8 * int'(al)) e[127-p] = a[8*int'(al)-1-(p-8)];
    return e;
  endfunction

  function automatic logic [31:0] exp_rx(input logic [7:0] c, input logic [23:0] a, input logic [1:0] al, input logic [3:0] rl);
    logic [31:0] acc = 32'd0;
    for (int k = 0; k < (rl > 4'd4 ? 4 : int'(rl)); k++) acc = {acc[23:0], slave_byte(c, a, 1 + int'(al) + k)};
    return acc;
  endfunction

  always @(posedge sck) begin
    if (cs) glitches++;
    else begin
      if (rises == cs_base) mbits = '0;
      else if ($time - last_rise != per_exp) bad_per++;
      mbits[127 - (rises - cs_base)] = mosi;
      last_rise = $time;
      rises++;
    end
  end
  always @(negedge cs) cs_base = rises;
  always @(negedge sck or negedge cs) begin
    int p;
    logic [7:0] b;
    if (!cs) begin
      p = rises - cs_base;
      b = slave_byte(mbits[127:120], mbits[119:96], p / 8);
      miso <= b[7 - p % 8];
    end
  end
  always @(negedge clk) begin
    if (done) dones++;
    if (!cs) cs_low++;
  end

  task automatic run_txn(input logic [7:0] c, input logic [23:0] a, input logic [1:0] al,
                         input logic [3:0] rl, input int start_at, input int abort_at);
    int d0, r0, c0, g0, b0;
    bit fin = 0;
    d0 = dones; r0 = rises; c0 = cs_low; g0 = glitches; b0 = bad_per;
    @(negedge clk);
    cmd = c; addr = a; addr_len = al; rx_len = rl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    o_busy0 = busy; o_cs0 = cs; o_mosi0 = mosi; o_overlap = 1'b0;
    cmd = 8'($urandom); addr = 24'($urandom); addr_len = 2'($urandom); rx_len = 4'($urandom);
    for (int i = 0; i < 4000 && !fin; i++) begin
      @(negedge clk);
      if (done && busy) o_overlap = 1'b1;
      if (start_at >= 0) start = (rises - r0 == start_at);
      if (abort_at >= 0 && rises - r0 >= abort_at) begin
        reset = 1'b0;
        #1;
        o_ab_cs = cs; o_ab_busy = busy; o_ab_rx = rx; start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        fin = 1;
      end else if (done) begin
        repeat (2) @(negedge clk);
        fin = 1;
      end
    end
    start = 1'b0;
    if (!fin) begin
      checks++; fails++;
      $display("FAIL txn_timeout: no done after 4000 clks, cmd=%02h", c);
    end
    o_rx = rx; o_mbits = mbits; o_rises = rises - r0; o_dones = dones - d0;
    o_cslow = cs_low - c0; o_glitch = glitches - g0; o_badper = bad_per - b0;
    repeat (4) @(negedge clk);
    o_rx_late = rx;
  endtask

  task automatic test_reset();
    #5 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (cs !== 1'b1 || cs1 !== 1'b1) begin fails++; $display("FAIL reset_cs: got %b%b want 11", cs, cs1); end
    checks++; if (sck !== 1'b0 || sck1 !== 1'b1) begin fails++; $display("FAIL reset_sck: got %b%b want 01", sck, sck1); end
    checks++; if (mosi !== 1'b0 || rx !== 32'd0) begin fails++; $display("FAIL reset_mosi_rx: got %b %h want 0 0", mosi, rx); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rdid();
    run_txn(8'h9F, 24'h0, 2'd0, 4'd3, -1, -1);
    checks++; if (o_rises !== 32) begin fails++; $display("FAIL rdid_rises: got %0d want 32", o_rises); end
    checks++; if (o_mbits !== exp_mosi(8'h9F, 24'h0, 2'd0, 4'd3)) begin fails++; $display("FAIL rdid_mosi: got %h want %h", o_mbits, exp_mosi(8'h9F, 24'h0, 2'd0, 4'd3)); end
    checks++; if (o_rx !== 32'h00202015) begin fails++; $display("FAIL rdid_rx: got %h want 00202015", o_rx); end
    checks++; if (o_rx_late !== 32'h00202015) begin fails++; $display("FAIL rdid_rx_hold: got %h want 00202015", o_rx_late); end
    checks++; if (o_dones !== 1) begin fails++; $display("FAIL rdid_done: got %0d want 1", o_dones); end
    checks++; if (o_cslow !== 66) begin fails++; $display("FAIL rdid_cs_low: got %0d want 66", o_cslow); end
    checks++; if (o_badper !== 0 || o_glitch !== 0) begin fails++; $display("FAIL rdid_sck: bad periods %0d glitches %0d want 0 0", o_badper, o_glitch); end
    checks++; if ({o_busy0, o_cs0, o_mosi0} !== 3'b101) begin fails++; $display("FAIL rdid_first_cycle: got %b want 101", {o_busy0, o_cs0, o_mosi0}); end
    checks++; if (o_overlap !== 1'b0) begin fails++; $display("FAIL rdid_busy_at_done: got 1 want 0"); end
  endtask

  task automatic test_wren();
    run_txn(8'h06, 24'hABCDEF, 2'd0, 4'd0, -1, -1);
    checks++; if (o_rises !== 8) begin fails++; $display("FAIL wren_rises: got %0d want 8", o_rises); end
    checks++; if (o_mbits !== exp_mosi(8'h06, 24'h0, 2'd0, 4'd0)) begin fails++; $display("FAIL wren_mosi: got %h", o_mbits); end
    checks++; if (o_rx !== 32'd0) begin fails++; $display("FAIL wren_rx: got %h want 0", o_rx); end
    checks++; if (o_cslow !== 18 || o_dones !== 1) begin fails++; $display("FAIL wren_cs_done: got %0d/%0d want 18/1", o_cslow, o_dones); end
  endtask

  task automatic test_read();
    logic [31:0] e;
    e = exp_rx(8'h03, 24'h0, 2'd3, 4'd4);
    run_txn(8'h03, 24'h0, 2'd3, 4'd4, -1, -1);
    checks++; if (o_rises !== 64) begin fails++; $display("FAIL read_rises: got %0d want 64", o_rises); end
    checks++; if (o_mbits !== exp_mosi(8'h03, 24'h0, 2'd3, 4'd4)) begin fails++; $display("FAIL read_mosi: got %h", o_mbits); end
    checks++; if (o_rx !== e) begin fails++; $display("FAIL read_rx: got %h want %h", o_rx, e); end
    checks++; if (o_dones !== 1) begin fails++; $display("FAIL read_done: got %0d want 1", o_dones); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      logic [7:0] c;
      logic [23:0] a;
      logic [1:0] al;
      logic [3:0] rl;
      int n;
      c = 8'($urandom); a = 24'($urandom); al = 2'($urandom); rl = 4'($urandom_range(0, 7));
      if (c == 8'h9F || c == 8'h03) c = 8'h5A;
      n = n_of(al, rl);
      run_txn(c, a, al, rl, -1, -1);
      checks++; if (o_rises !== n) begin fails++; $display("FAIL rand_rises[%0d]: got %0d want %0d", t, o_rises, n); end
      checks++; if (o_mbits !== exp_mosi(c, a, al, rl)) begin fails++; $display("FAIL rand_mosi[%0d]: got %h want %h", t, o_mbits, exp_mosi(c, a, al, rl)); end
      checks++; if (o_rx_late !== exp_rx(c, a, al, rl)) begin fails++; $display("FAIL rand_rx[%0d]: got %h want %h", t, o_rx_late, exp_rx(c, a, al, rl)); end
      checks++; if (o_cslow !== 2 * n + 2 || o_dones !== 1) begin fails++; $display("FAIL rand_cs_done[%0d]: got %0d/%0d want %0d/1", t, o_cslow, o_dones, 2 * n + 2); end
    end
  endtask

  task automatic test_start_in_shift();
    run_txn(8'h9F, 24'h0, 2'd0, 4'd3, 10, -1);
    checks++; if (o_rises !== 32 || o_dones !== 1) begin fails++; $display("FAIL restart_ignored: rises %0d dones %0d want 32 1", o_rises, o_dones); end
    checks++; if (o_rx !== 32'h00202015) begin fails++; $display("FAIL restart_rx: got %h want 00202015", o_rx); end
  endtask

  task automatic test_reset_abort();
    run_txn(8'h9F, 24'h0, 2'd0, 4'd3, -1, 12);
    checks++; if ({o_ab_cs, o_ab_busy} !== 2'b10) begin fails++; $display("FAIL abort_cs_busy: got %b want 10", {o_ab_cs, o_ab_busy}); end
    checks++; if (o_ab_rx !== 32'd0) begin fails++; $display("FAIL abort_rx: got %h want 0", o_ab_rx); end
    checks++; if (o_dones !== 0) begin fails++; $display("FAIL abort_no_done: got %0d want 0", o_dones); end
    run_txn(8'h9F, 24'h0, 2'd0, 4'd3, -1, -1);
    checks++; if (o_rx !== 32'h00202015 || o_rises !== 32 || o_dones !== 1) begin fails++; $display("FAIL abort_recover: rx %h rises %0d dones %0d want 00202015 32 1", o_rx, o_rises, o_dones); end
  endtask

  task automatic test_mode3();
    sel = 1'b1; per_exp = 120;
    repeat (3) @(negedge clk);
    checks++; if (sck !== 1'b1) begin fails++; $display("FAIL mode3_idle_sck: got %b want 1", sck); end
    run_txn(8'h9F, 24'h0, 2'd0, 4'd3, -1, -1);
    checks++; if (o_rises !== 32 || o_badper !== 0 || o_glitch !== 0) begin fails++; $display("FAIL mode3_sck: rises %0d bad periods %0d glitches %0d want 32 0 0", o_rises, o_badper, o_glitch); end
    checks++; if (o_mbits !== exp_mosi(8'h9F, 24'h0, 2'd0, 4'd3)) begin fails++; $display("FAIL mode3_mosi: got %h", o_mbits); end
    checks++; if (o_rx !== 32'h00202015) begin fails++; $display("FAIL mode3_rx: got %h want 00202015", o_rx); end
    checks++; if (o_cslow !== 198 || o_dones !== 1) begin fails++; $display("FAIL mode3_cs_done: got %0d/%0d want 198/1", o_cslow, o_dones); end
    checks++; if (sck !== 1'b1) begin fails++; $display("FAIL mode3_end_sck: got %b want 1", sck); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      stream[i] = 8'($urandom);
    end
    test_reset();
    test_rdid();
    test_wren();
    test_read();
    test_random();
    test_start_in_shift();
    test_reset_abort();
    test_mode3();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
